// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
//   PC_W / INST_W    : address and instruction word widths
//   PC_INC           : sequential PC step in bytes
//   RESET_PC_DEFAULT : default first fetch address after reset
//   state_e          : fetch FSM states
package ifu_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_INC = 4;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    OUT,
    DRAIN
  } state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-unit signal bundle: imem request/response, IDU handshake, redirect and halt.
//   master : the fetch unit (drives mem_req_*, inst_*)
//   slave  : memory / IDU / control side (drives ready, response, redirect, halt)
interface ifu_fetch_if;
  import ifu_pkg::*;

  logic              mem_req_valid;
  logic [PC_W-1:0]   mem_req_addr;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [INST_W-1:0] mem_rsp_data;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [PC_W-1:0]   inst_pc;
  logic              inst_ready;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              halt;

  modport master (
    output mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
           redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
           redirect_valid, redirect_pc, halt
  );

endinterface

// File: rtl/ifu_fetch.sv
// Instruction-fetch initiator: holds the PC, issues one word-aligned fetch at a
// time, hands the returned word to the IDU, and follows redirects while dropping
// responses made stale by them.
// Ports:
//   clk : clock, posedge
//   rst : asynchronous active-high reset
//   bus : ifu_fetch_if.master (mem_req_*, mem_rsp_*, inst_*, redirect_*, halt)
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  ifu_fetch_if.master  bus
);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     req_pc_q, req_pc_d;
  logic [PC_W-1:0]     inst_pc_q, inst_pc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                inst_valid_q, inst_valid_d;
  logic                req_valid_c;
  logic                req_fire_c;

  // Request is decoded from registered state plus halt only.
  assign req_valid_c       = (state_q == REQ) && !bus.halt;
  assign req_fire_c        = req_valid_c && bus.mem_req_ready;
  assign bus.mem_req_valid = req_valid_c;
  assign bus.mem_req_addr  = (state_q == BOOT) ? '0 : {pc_q[PC_W-1:2], 2'b00};

  assign bus.inst_valid    = inst_valid_q;
  assign bus.inst          = inst_q;
  assign bus.inst_pc       = inst_pc_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  // Next-state logic; a redirect outranks every other event in its cycle.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;

    case (state_q)
      BOOT: begin
        state_d = REQ;
        if (bus.redirect_valid) pc_d = bus.redirect_pc;
      end

      REQ: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_pc;
          // An accepted request is already in flight and must be drained.
          state_d = req_fire_c ? DRAIN : REQ;
        end else if (req_fire_c) begin
          req_pc_d = pc_q;
          state_d  = WAIT;
        end
      end

      WAIT: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_pc;
          state_d = bus.mem_rsp_valid ? REQ : DRAIN;
        end else if (bus.mem_rsp_valid) begin
          inst_d       = bus.mem_rsp_data;
          inst_pc_d    = req_pc_q;
          inst_valid_d = 1'b1;
          state_d      = OUT;
        end
      end

      OUT: begin
        if (bus.redirect_valid) begin
          pc_d         = bus.redirect_pc;
          inst_valid_d = 1'b0;
          state_d      = REQ;
        end else if (bus.inst_ready) begin
          pc_d         = pc_q + PC_W'(PC_INC);
          inst_valid_d = 1'b0;
          state_d      = REQ;
        end
      end

      DRAIN: begin
        if (bus.redirect_valid) pc_d = bus.redirect_pc;
        if (bus.mem_rsp_valid)  state_d = REQ;
      end

      default: state_d = BOOT;
    endcase
  end

  // Only one request may be outstanding, so responses are legal only here.
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    bus.mem_rsp_valid |-> (state_q == WAIT || state_q == DRAIN));

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios, a memory responder with adjustable
// latency, and a program-order model checked every cycle.
module tb_ifu_fetch;

  logic clk = 1'b0;
  logic rst;

  ifu_fetch_if bus ();

  ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  // staged inputs, applied at the next falling edge
  logic        s_rst, s_ready, s_iready, s_halt, s_redir;
  logic [31:0] s_rpc;

  // memory responder state
  int          lat;
  int          rsp_cnt;
  logic [31:0] rsp_addr;
  logic        last_hs;

  // model state
  logic [31:0] m_pc;
  logic        outstanding;
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  int          got_cyc[$];

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h1357_9BDF;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void timeout_fail(input string name);
    vectors++;
    errors++;
    $display("FAIL %s: no progress within cycle budget", name);
  endfunction

  // One clock cycle: drive inputs at the falling edge, then look at what will
  // happen on the following rising edge.
  task automatic tick();
    @(negedge clk);
    rst                = s_rst;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = 32'hDEAD_BEEF;
    if (rsp_cnt != 0) begin
      rsp_cnt = rsp_cnt - 1;
      if (rsp_cnt == 0) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = memword(rsp_addr);
      end
    end
    bus.mem_req_ready  = s_ready;
    bus.inst_ready     = s_iready;
    bus.halt           = s_halt;
    bus.redirect_valid = s_redir;
    bus.redirect_pc    = s_rpc;
    #2;
    last_hs = bus.mem_req_valid && bus.mem_req_ready && !rst;
    if (last_hs) begin
      rsp_cnt  = lat;
      rsp_addr = bus.mem_req_addr;
    end
  endtask

  task automatic wait_deliver(input int n, input string name);
    int b = 0;
    while (got_pc.size() < n && b < 80) begin
      tick();
      b++;
    end
    if (got_pc.size() < n) timeout_fail(name);
  endtask

  task automatic wait_req_hs(input string name);
    int b = 0;
    while (!last_hs && b < 80) begin
      tick();
      b++;
    end
    if (!last_hs) timeout_fail(name);
  endtask

  task automatic wait_inst_valid(input string name);
    int b = 0;
    do begin
      tick();
      b++;
    end while (!bus.inst_valid && b < 80);
    if (!bus.inst_valid) timeout_fail(name);
  endtask

  task automatic wait_req_seen(input string name);
    int b = 0;
    do begin
      tick();
      b++;
    end while (!bus.mem_req_valid && b < 80);
    if (!bus.mem_req_valid) timeout_fail(name);
  endtask

  // Program-order model: next PC to deliver, one outstanding fetch at most.
  always @(negedge clk) begin
    #3;
    cyc++;
    if (rst) begin
      chk("reset_outputs", 32'(bus.mem_req_valid) | 32'(bus.inst_valid) |
          bus.mem_req_addr | bus.inst | bus.inst_pc, 32'h0);
      m_pc        = 32'h8000_0000;
      outstanding = 1'b0;
    end else begin
      if (bus.halt) chk("halt_gates_req", 32'(bus.mem_req_valid), 32'h0);
      if (bus.mem_req_valid) begin
        chk("req_addr", bus.mem_req_addr, {m_pc[31:2], 2'b00});
        chk("one_outstanding", 32'(outstanding || bus.inst_valid), 32'h0);
      end
      if (bus.inst_valid) begin
        chk("inst_pc", bus.inst_pc, m_pc);
        chk("inst_word", bus.inst, memword(m_pc));
      end
      if (bus.mem_rsp_valid) outstanding = 1'b0;
      if (bus.mem_req_valid && bus.mem_req_ready) outstanding = 1'b1;
      if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
        got_pc.push_back(bus.inst_pc);
        got_inst.push_back(bus.inst);
        got_cyc.push_back(cyc);
      end
      if (bus.redirect_valid) m_pc = bus.redirect_pc;
      else if (bus.inst_valid && bus.inst_ready) m_pc = m_pc + 32'd4;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "bench timeout");
  end

  initial begin
    int base;
    s_rst = 1'b1; s_ready = 1'b1; s_iready = 1'b1; s_halt = 1'b0;
    s_redir = 1'b0; s_rpc = '0;
    lat = 1; rsp_cnt = 0; rsp_addr = '0; last_hs = 1'b0;
    m_pc = 32'h8000_0000; outstanding = 1'b0;
    rst = 1'b1;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
    bus.inst_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.halt = 1'b0;
    repeat (3) tick();

    // reset release, 1-cycle memory, IDU always ready
    s_rst = 1'b0;
    tick();
    chk("boot_no_req", 32'(bus.mem_req_valid), 32'h0);
    chk("boot_addr", bus.mem_req_addr, 32'h0);
    tick();
    chk("first_req_valid", 32'(bus.mem_req_valid), 32'h1);
    chk("first_req_addr", bus.mem_req_addr, 32'h8000_0000);
    wait_deliver(3, "seq_deliver");
    chk("seq_pc0", got_pc[0], 32'h8000_0000);
    chk("seq_pc1", got_pc[1], 32'h8000_0004);
    chk("seq_pc2", got_pc[2], 32'h8000_0008);
    chk("seq_inst0", got_inst[0], 32'h9357_9BDF);
    chk("seq_inst2", got_inst[2], 32'h9357_9BD7);
    chk("throughput", 32'(got_cyc[1] - got_cyc[0]), 32'd3);

    // IDU stall in OUT
    s_iready = 1'b0;
    wait_inst_valid("stall_out");
    chk("stall_pc", bus.inst_pc, 32'h8000_000C);
    repeat (5) tick();
    chk("stall_hold_pc", bus.inst_pc, 32'h8000_000C);
    chk("stall_hold_inst", bus.inst, 32'h9357_9BD3);
    chk("stall_no_req", 32'(bus.mem_req_valid), 32'h0);
    s_iready = 1'b1;
    tick();
    lat = 4;
    tick();
    chk("after_stall_req", 32'(bus.mem_req_valid), 32'h1);
    chk("after_stall_addr", bus.mem_req_addr, 32'h8000_0010);

    // redirect while waiting; response lands three cycles later
    s_redir = 1'b1; s_rpc = 32'h8000_0100;
    tick();
    s_redir = 1'b0;
    lat = 1;
    wait_req_hs("wait_redir_req");
    chk("wait_redir_addr", rsp_addr, 32'h8000_0100);
    wait_deliver(5, "wait_redir_deliver");
    chk("wait_redir_pc", got_pc[4], 32'h8000_0100);
    chk("wait_redir_inst", got_inst[4], 32'h9357_9ADF);

    // redirect in the same cycle as a request handshake
    s_ready = 1'b0;
    wait_req_seen("req_hs_redir");
    s_ready = 1'b1; s_redir = 1'b1; s_rpc = 32'h8000_0200; lat = 2;
    tick();
    s_redir = 1'b0;
    base = got_pc.size();
    tick();
    wait_req_hs("drain_req");
    chk("drain_addr", rsp_addr, 32'h8000_0200);
    lat = 3;
    wait_deliver(base + 1, "drain_deliver");
    chk("drain_pc", got_pc[base], 32'h8000_0200);
    chk("drain_inst", got_inst[base], 32'h9357_99DF);

    // redirect (unaligned target) in the same cycle as the response
    wait_req_hs("rsp_redir_req");
    repeat (2) tick();
    s_redir = 1'b1; s_rpc = 32'h8000_0302; s_ready = 1'b0;
    tick();
    s_redir = 1'b0;
    tick();
    chk("rsp_redir_no_inst", 32'(bus.inst_valid), 32'h0);
    chk("rsp_redir_req", 32'(bus.mem_req_valid), 32'h1);
    chk("rsp_redir_addr", bus.mem_req_addr, 32'h8000_0300);

    // unaccepted request holds, then halt gates it
    repeat (4) begin
      tick();
      chk("backpressure_valid", 32'(bus.mem_req_valid), 32'h1);
      chk("backpressure_addr", bus.mem_req_addr, 32'h8000_0300);
    end
    s_halt = 1'b1; s_ready = 1'b1; lat = 1;
    repeat (3) begin
      tick();
      chk("halt_no_req", 32'(bus.mem_req_valid), 32'h0);
    end
    s_halt = 1'b0;
    base = got_pc.size();
    tick();
    chk("halt_resume_valid", 32'(bus.mem_req_valid), 32'h1);
    chk("halt_resume_addr", bus.mem_req_addr, 32'h8000_0300);
    wait_deliver(base + 2, "halt_deliver");
    chk("unaligned_pc", got_pc[base], 32'h8000_0302);
    chk("unaligned_inst", got_inst[base], 32'h9357_98DF);
    chk("unaligned_next_pc", got_pc[base + 1], 32'h8000_0306);
    chk("unaligned_next_inst", got_inst[base + 1], 32'h9357_98DB);

    // redirect in OUT alongside inst_ready, to a target that wraps
    lat = 2;
    s_iready = 1'b0;
    wait_inst_valid("out_redir");
    s_iready = 1'b1; s_redir = 1'b1; s_rpc = 32'hFFFF_FFFC;
    tick();
    s_redir = 1'b0;
    base = got_pc.size();
    tick();
    chk("out_redir_valid", 32'(bus.mem_req_valid), 32'h1);
    chk("out_redir_addr", bus.mem_req_addr, 32'hFFFF_FFFC);
    wait_deliver(base + 2, "wrap_deliver");
    chk("wrap_pc0", got_pc[base], 32'hFFFF_FFFC);
    chk("wrap_inst0", got_inst[base], 32'hECA8_6423);
    chk("wrap_pc1", got_pc[base + 1], 32'h0000_0000);
    chk("wrap_inst1", got_inst[base + 1], 32'h1357_9BDF);

    // asynchronous reset while waiting, response due next cycle
    wait_req_hs("rst_wait_req");
    s_rst = 1'b1;
    tick();
    chk("rst_req_valid", 32'(bus.mem_req_valid), 32'h0);
    chk("rst_req_addr", bus.mem_req_addr, 32'h0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    tick();
    s_rst = 1'b0;
    base = got_pc.size();
    tick();
    chk("rst_boot_no_req", 32'(bus.mem_req_valid), 32'h0);
    tick();
    chk("restart_valid", 32'(bus.mem_req_valid), 32'h1);
    chk("restart_addr", bus.mem_req_addr, 32'h8000_0000);
    wait_deliver(base + 1, "restart_deliver");
    chk("restart_pc", got_pc[base], 32'h8000_0000);
    chk("restart_inst", got_inst[base], 32'h9357_9BDF);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
